// File: rtl/trace_fifo.sv
// Synchronous trace FIFO: unstallable producer, valid/ready consumer with first-word
// fall-through, selectable overflow policy, flush, occupancy/watermark and drop counter.
module trace_fifo #(
  parameter int ENTRY_WIDTH   = 32,
  parameter int DEPTH         = 8,
  parameter int OVERFLOW_MODE = 0,
  parameter int OVF_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [ENTRY_WIDTH-1:0]   in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [ENTRY_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   max_count,
  output logic [OVF_WIDTH-1:0]     overflow_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  function automatic logic [OVF_WIDTH-1:0] sat_inc(input logic [OVF_WIDTH-1:0] val);
    logic [OVF_WIDTH-1:0] res;
    if (&val) begin
      res = val;
    end else begin
      res = val + OVF_WIDTH'(1);
    end
    return res;
  endfunction

  logic [ENTRY_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r, wr_ptr_nx_s, rd_ptr_nx_s;
  logic [CNT_W-1:0]       count_r, count_nx_s, max_count_r, max_count_nx_s;
  logic [OVF_WIDTH-1:0]   ovf_count_r, ovf_count_nx_s;
  logic                   we_s, push_s, pop_s, full_s, empty_s;

  assign full_s  = (count_r == CNT_DEPTH);
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign push_s  = in_valid;
  assign pop_s   = !empty_s && out_ready;

  // Next-state for pointers, occupancy, watermark and drop counter.
  always_comb begin
    wr_ptr_nx_s    = wr_ptr_r;
    rd_ptr_nx_s    = rd_ptr_r;
    count_nx_s     = count_r;
    ovf_count_nx_s = ovf_count_r;
    we_s           = 1'b0;
    if (flush) begin
      wr_ptr_nx_s = {PTR_W{1'b0}};
      rd_ptr_nx_s = {PTR_W{1'b0}};
      count_nx_s  = {CNT_W{1'b0}};
    end else if (push_s && pop_s) begin
      we_s        = 1'b1;
      wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
      rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
    end else if (push_s && !full_s) begin
      we_s        = 1'b1;
      wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
      count_nx_s  = count_r + CNT_ONE;
    end else if (push_s) begin
      ovf_count_nx_s = sat_inc(ovf_count_r);
      // Overwrite mode: wr_ptr == rd_ptr when full, so the oldest slot is replaced.
      if (OVERFLOW_MODE == 1) begin
        we_s        = 1'b1;
        wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
        rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
      end else begin
        we_s = 1'b0;
      end
    end else if (pop_s) begin
      rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
      count_nx_s  = count_r - CNT_ONE;
    end else begin
      we_s = 1'b0;
    end
    if (count_nx_s > max_count_r) begin
      max_count_nx_s = count_nx_s;
    end else begin
      max_count_nx_s = max_count_r;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      max_count_r <= {CNT_W{1'b0}};
      ovf_count_r <= {OVF_WIDTH{1'b0}};
    end else begin
      wr_ptr_r    <= wr_ptr_nx_s;
      rd_ptr_r    <= rd_ptr_nx_s;
      count_r     <= count_nx_s;
      max_count_r <= max_count_nx_s;
      ovf_count_r <= ovf_count_nx_s;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  assign out_valid      = !empty_s;
  assign out_data       = empty_s ? {ENTRY_WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign count          = count_r;
  assign full           = full_s;
  assign empty          = empty_s;
  assign max_count      = max_count_r;
  assign overflow_count = ovf_count_r;

endmodule
